tdc_hit_buffer: RTL and testbench
=================================

Name: tdc_hit_buffer

Overview:
- Per-frame multi-hit result buffer between the TDC measurement core and the AXI-stream readout; runs entirely in the logic clock domain.
- Collects hit records (tof, intensity) during a frame window and keeps up to DEPTH of them: the strongest, or the first arrivals, depending on MODE.
- At frame end, streams the retained hits out with count, last flag and per-frame statistics.
- Generalises the fixed 3-deep, 10-bit strongest-hit selection with parametrised widths, depth and mode, empty-frame reporting and overrun detection.

Parameters:
TOF_W, 15, width of a tof record
INT_W, 5, width of an intensity record
DEPTH, 3, maximum retained hits per frame (1..8)
MODE, 0, 0 = keep strongest DEPTH hits; 1 = keep first DEPTH hits
CNT_W, 8, width of the saturating hit/drop counters

Ports:
clk  in  1  logic clock (250 MHz)
rst  in  1  asynchronous reset, active-high
frame_start  in  1  single-cycle pulse; opens a frame
frame_end  in  1  single-cycle pulse; closes a frame
hit_valid  in  1  single-cycle qualifier for a hit record
hit_tof  in  TOF_W  hit time of flight
hit_int  in  INT_W  hit intensity
TDC_Odata  out  TOF_W  stream tof
TDC_Oint  out  INT_W  stream intensity
TDC_Onum  out  $clog2(DEPTH+1)  number of hits in current frame
TDC_Ovalid  out  1  stream valid
TDC_Olast  out  1  last beat of frame
TDC_Oready  in  1  stream ready
hit_cnt  out  CNT_W  hits seen in last frame, saturating
drop_cnt  out  CNT_W  hits discarded in last frame, saturating
overrun  out  1  sticky: frame_start arrived while draining

Behaviour:
- Reset values: all outputs 0; state IDLE; all slots and counters cleared.
- States:
  - IDLE: frame_start -> COLLECT.
  - COLLECT: frame_start -> COLLECT (restart; buffer and counters cleared; old frame abandoned). frame_end -> DRAIN.
  - DRAIN: beat index reaches num-1 and handshake occurs -> IDLE.
- Collect rules, on hit_valid in COLLECT:
  - hit_cnt increments (saturates at all-ones).
  - If fill < DEPTH: write to slot[fill]; fill increments.
  - Else, MODE 0: find the lowest-intensity slot (lowest index on ties). Replace it only if hit_int > that slot's intensity (strict); otherwise drop.
  - Else, MODE 1: drop.
  - Every drop increments drop_cnt (saturating).
- Hit-window edges:
  - hit_valid in the same cycle as frame_end is included.
  - hit_valid in the same cycle as frame_start is ignored; collection starts the next cycle.
  - hit_valid in IDLE or DRAIN is ignored and not counted.
- Drain:
  - TDC_Ovalid rises the cycle after frame_end (1-cycle latency).
  - Beats go out in slot order 0..fill-1.
  - TDC_Onum = fill for every beat of the frame.
  - TDC_Olast = 1 on beat fill-1.
  - Empty frame (fill = 0): exactly one beat with Odata = 0, Oint = 0, Onum = 0, Olast = 1.
- Handshake (AXI-stream):
  - A beat transfers when TDC_Ovalid & TDC_Oready.
  - Data, int, num and last are held stable while valid & !ready.
  - Valid never drops before the transfer.
  - Valid drops the cycle after the last transfer unless the next beat follows back-to-back.
- Statistics:
  - hit_cnt and drop_cnt are snapshotted at frame_end and held until the next frame's frame_end.
  - Internal running counters are cleared at frame_start.
- Overrun:
  - frame_start in DRAIN sets overrun and is ignored; the drain completes normally.
  - overrun clears only on rst.
- Simultaneous frame_start and frame_end in COLLECT: frame_start wins (restart).
- rst mid-operation: immediate return to reset values; no partial beats.
- Width rules:
  - Comparisons are unsigned.
  - No arithmetic on tof; the record passes through unchanged.
  - The fill counter is $clog2(DEPTH+1) bits.

Decomposition:
- Shared package tdc_pkg holds:
  - state encoding (IDLE, COLLECT, DRAIN)
  - MODE constants (MODE_STRONGEST = 0, MODE_FIRST = 1)
  - default TOF_W and INT_W
  - a packed hit-record typedef {tof, int}
- Sub-module tdc_min_find: combinational argmin over DEPTH intensities, lowest index on ties. Outputs min index and min value.

Test Plan:
- DEPTH=3, MODE 0. Frame hits with int 4, 9, 2, 7, 2 -> beats int 4, 9, 7 (slot order), Onum = 3, Olast on 3rd beat, hit_cnt = 5, drop_cnt = 2.
- MODE 1, same hits -> beats int 4, 9, 2; drop_cnt = 2.
- Empty frame (frame_start then frame_end, no hits) -> single beat with Onum = 0, Olast = 1, data 0, hit_cnt = 0.
- Backpressure: 2-hit frame with TDC_Oready low for 5 cycles after valid -> beat 0 stable for all 5 cycles; 2 transfers total; Olast only on the 2nd.
- frame_start pulsed during DRAIN -> overrun = 1; current frame drains intact; next frame_end produces no stream until a new frame_start in IDLE.
- Ties and edges:
  - Full buffer int {3, 3, 5} receives int 3 -> dropped.
  - Then int 4 -> replaces slot 0.
  - A hit coincident with frame_end is included.
  - Assert rst mid-drain -> TDC_Ovalid = 0 the same cycle.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC per-frame hit buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int MODE_STRONGEST = 0;
    localparam int MODE_FIRST     = 1;

    localparam int TOF_W_DEF = 15;
    localparam int INT_W_DEF = 5;

    // One hit record at the default widths.
    typedef struct packed {
        logic [TOF_W_DEF-1:0] tof;
        logic [INT_W_DEF-1:0] intensity;
    } hit_t;

endpackage

// File: rtl/tdc_hit_buffer_if.sv
// Hit input bus plus AXI-stream style readout of the TDC hit buffer.
// Latency: n/a (wiring only).
// Backpressure: TDC_Oready from the readout side stalls the stream beats.
// Modports: master = measurement core / readout side, slave = hit buffer.
interface tdc_hit_buffer_if
    import tdc_pkg::*;
#(
    parameter int TOF_W = TOF_W_DEF,
    parameter int INT_W = INT_W_DEF,
    parameter int DEPTH = 3
);
    localparam int NUM_W = $clog2(DEPTH + 1);

    logic             frame_start;
    logic             frame_end;
    logic             hit_valid;
    logic [TOF_W-1:0] hit_tof;
    logic [INT_W-1:0] hit_int;

    logic [TOF_W-1:0] TDC_Odata;
    logic [INT_W-1:0] TDC_Oint;
    logic [NUM_W-1:0] TDC_Onum;
    logic             TDC_Ovalid;
    logic             TDC_Olast;
    logic             TDC_Oready;

    modport master (
        output frame_start, frame_end, hit_valid, hit_tof, hit_int, TDC_Oready,
        input  TDC_Odata, TDC_Oint, TDC_Onum, TDC_Ovalid, TDC_Olast
    );

    modport slave (
        input  frame_start, frame_end, hit_valid, hit_tof, hit_int, TDC_Oready,
        output TDC_Odata, TDC_Oint, TDC_Onum, TDC_Ovalid, TDC_Olast
    );

endinterface

// File: rtl/tdc_min_find.sv
// Argmin over N unsigned values; lowest index wins on ties.
// Latency: combinational.
// Backpressure: none.
// Ports: vals (N x W) in; min_idx, min_val out.
module tdc_min_find #(
    parameter int N     = 3,
    parameter int W     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0][W-1:0] vals,
    output logic [IDX_W-1:0]    min_idx,
    output logic [W-1:0]        min_val
);

    // Strict less-than keeps the earlier index when values are equal.
    always_comb begin
        min_idx = '0;
        min_val = vals[0];
        for (int i = 1; i < N; i++) begin
            if (vals[i] < min_val) begin
                min_val = vals[i];
                min_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tdc_hit_buffer.sv
// Per-frame buffer keeping up to DEPTH hits (strongest or first), streamed out at frame end.
// Latency: first beat valid the cycle after frame_end; one beat per accepted handshake.
// Backpressure: beats held stable while TDC_Ovalid & !TDC_Oready; hits are never backpressured.
// Ports: clk, rst (async, active-high); bus (slave: hit input + stream output);
//        hit_cnt / drop_cnt (per-frame statistics snapshot); overrun (sticky).
module tdc_hit_buffer
    import tdc_pkg::*;
#(
    parameter int TOF_W = TOF_W_DEF,
    parameter int INT_W = INT_W_DEF,
    parameter int DEPTH = 3,
    parameter int MODE  = MODE_STRONGEST,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    tdc_hit_buffer_if.slave  bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overrun
);

    localparam int                FILL_W  = $clog2(DEPTH + 1);
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);

    typedef struct packed {
        logic [TOF_W-1:0] tof;
        logic [INT_W-1:0] intensity;
    } rec_t;

    state_t                      state;
    rec_t                        slots     [DEPTH];
    rec_t                        slots_nxt [DEPTH];
    logic [FILL_W-1:0]           fill;
    logic [FILL_W-1:0]           fill_nxt;
    logic [FILL_W-1:0]           beat;
    logic [FILL_W-1:0]           beat_inc;
    logic [CNT_W-1:0]            hit_run;
    logic [CNT_W-1:0]            drop_run;
    logic [CNT_W-1:0]            hit_run_nxt;
    logic [CNT_W-1:0]            drop_run_nxt;
    logic [DEPTH-1:0][INT_W-1:0] slot_int;
    logic [IDX_W-1:0]            min_idx;
    logic [INT_W-1:0]            min_val;
    rec_t                        hit_rec;
    rec_t                        first_rec;
    rec_t                        next_rec;
    logic                        hit_acc;
    logic                        hit_drop;
    logic                        xfer;

    assign hit_rec = '{tof: bus.hit_tof, intensity: bus.hit_int};

    // A hit on the frame_start cycle belongs to neither the old nor the new frame.
    assign hit_acc = (state == COLLECT) && bus.hit_valid && !bus.frame_start;
    assign xfer    = bus.TDC_Ovalid && bus.TDC_Oready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_int[i] = slots[i].intensity;
        end
    end

    tdc_min_find #(
        .N     (DEPTH),
        .W     (INT_W),
        .IDX_W (IDX_W)
    ) u_min_find (
        .vals    (slot_int),
        .min_idx (min_idx),
        .min_val (min_val)
    );

    always_comb begin
        slots_nxt = slots;
        fill_nxt  = fill;
        hit_drop  = 1'b0;
        if (hit_acc) begin
            if (fill < DEPTH_F) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (fill == FILL_W'(i)) begin
                        slots_nxt[i] = hit_rec;
                    end
                end
                fill_nxt = fill + FILL_W'(1);
            end else begin
                // Buffer full: one hit is lost either way -- the newcomer, or the
                // weakest retained hit it evicts -- so the drop counter always moves.
                hit_drop = 1'b1;
                if (MODE == MODE_STRONGEST && bus.hit_int > min_val) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (min_idx == IDX_W'(i)) begin
                            slots_nxt[i] = hit_rec;
                        end
                    end
                end
            end
        end
    end

    assign hit_run_nxt  = (hit_acc && hit_run != '1)   ? hit_run + CNT_W'(1)  : hit_run;
    assign drop_run_nxt = (hit_drop && drop_run != '1) ? drop_run + CNT_W'(1) : drop_run;

    // First beat is taken from the post-update slots so a hit coincident with
    // frame_end is already visible in beat 0.
    assign first_rec = (fill_nxt == '0) ? '0 : slots_nxt[0];
    assign beat_inc  = beat + FILL_W'(1);

    always_comb begin
        next_rec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (beat_inc == FILL_W'(i)) begin
                next_rec = slots[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            fill           <= '0;
            beat           <= '0;
            hit_run        <= '0;
            drop_run       <= '0;
            hit_cnt        <= '0;
            drop_cnt       <= '0;
            overrun        <= 1'b0;
            bus.TDC_Odata  <= '0;
            bus.TDC_Oint   <= '0;
            bus.TDC_Onum   <= '0;
            bus.TDC_Ovalid <= 1'b0;
            bus.TDC_Olast  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (bus.frame_start && state != DRAIN) begin
            // Open a frame, or restart one: frame_start wins over a coincident frame_end.
            state    <= COLLECT;
            fill     <= '0;
            hit_run  <= '0;
            drop_run <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                end
                COLLECT: begin
                    slots    <= slots_nxt;
                    fill     <= fill_nxt;
                    hit_run  <= hit_run_nxt;
                    drop_run <= drop_run_nxt;
                    if (bus.frame_end) begin
                        state          <= DRAIN;
                        hit_cnt        <= hit_run_nxt;
                        drop_cnt       <= drop_run_nxt;
                        beat           <= '0;
                        bus.TDC_Ovalid <= 1'b1;
                        bus.TDC_Odata  <= first_rec.tof;
                        bus.TDC_Oint   <= first_rec.intensity;
                        bus.TDC_Onum   <= fill_nxt;
                        // An empty frame still emits one zero beat, which is also the last.
                        bus.TDC_Olast  <= (fill_nxt <= FILL_W'(1));
                    end
                end
                DRAIN: begin
                    if (bus.frame_start) begin
                        overrun <= 1'b1;
                    end
                    if (xfer) begin
                        if (bus.TDC_Olast) begin
                            state          <= IDLE;
                            bus.TDC_Ovalid <= 1'b0;
                            bus.TDC_Odata  <= '0;
                            bus.TDC_Oint   <= '0;
                            bus.TDC_Onum   <= '0;
                            bus.TDC_Olast  <= 1'b0;
                        end else begin
                            beat          <= beat_inc;
                            bus.TDC_Odata <= next_rec.tof;
                            bus.TDC_Oint  <= next_rec.intensity;
                            bus.TDC_Olast <= (beat_inc == fill - FILL_W'(1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_hit_buffer.sv
// Bench for tdc_hit_buffer: one MODE 0 and one MODE 1 instance share the same stimulus.
// Expected beats are queued when frame_end is driven and popped as beats transfer.
// Table vectors cover selection rules; hand-written sequences cover stall, overrun and reset.
module tb_tdc_hit_buffer;
    import tdc_pkg::*;

    localparam int TOF_W = TOF_W_DEF;
    localparam int INT_W = INT_W_DEF;
    localparam int DEPTH = 3;
    localparam int CNT_W = 8;
    localparam int NUM_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TOF_W-1:0] tof;
        logic [INT_W-1:0] inten;
        logic [NUM_W-1:0] num;
        logic             last;
    } beat_t;

    typedef struct {
        int n;
        int ints [6];
        bit coinc;
        int n0;
        int idx0 [3];
        int n1;
        int idx1 [3];
        int hits;
        int drops;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             frame_start = 1'b0;
    logic             frame_end   = 1'b0;
    logic             hit_valid   = 1'b0;
    logic [TOF_W-1:0] hit_tof     = '0;
    logic [INT_W-1:0] hit_int     = '0;
    logic             ready       = 1'b1;

    logic [CNT_W-1:0] hit_cnt  [2];
    logic [CNT_W-1:0] drop_cnt [2];
    logic             overrun  [2];
    logic             vld      [2];
    beat_t            cur      [2];

    int    checks   = 0;
    int    failures = 0;
    int    beats_seen [2] = '{0, 0};
    beat_t q [2][$];
    vec_t  vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string detail);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, detail);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        tdc_hit_buffer_if #(.TOF_W(TOF_W), .INT_W(INT_W), .DEPTH(DEPTH)) bus ();

        assign bus.frame_start = frame_start;
        assign bus.frame_end   = frame_end;
        assign bus.hit_valid   = hit_valid;
        assign bus.hit_tof     = hit_tof;
        assign bus.hit_int     = hit_int;
        assign bus.TDC_Oready  = ready;

        tdc_hit_buffer #(
            .TOF_W (TOF_W),
            .INT_W (INT_W),
            .DEPTH (DEPTH),
            .MODE  (g),
            .CNT_W (CNT_W)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus.slave),
            .hit_cnt  (hit_cnt[g]),
            .drop_cnt (drop_cnt[g]),
            .overrun  (overrun[g])
        );

        assign vld[g] = bus.TDC_Ovalid;
        assign cur[g] = {bus.TDC_Odata, bus.TDC_Oint, bus.TDC_Onum, bus.TDC_Olast};

        beat_t prev_b     = '0;
        bit    prev_stall = 1'b0;
        beat_t exp_b;

        always @(negedge clk) begin
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk($sformatf("hold_valid_m%0d", g), 32'(vld[g]), 32'd1);
                    chk($sformatf("hold_beat_m%0d", g), 32'(cur[g]), 32'(prev_b));
                end
                if (vld[g] && ready) begin
                    beats_seen[g]++;
                    if (q[g].size() == 0) begin
                        flag($sformatf("unexpected_beat_m%0d", g),
                             $sformatf("got beat 0x%0h, expected no beat", cur[g]));
                    end else begin
                        exp_b = q[g].pop_front();
                        chk($sformatf("beat_m%0d", g), 32'(cur[g]), 32'(exp_b));
                    end
                end
                prev_stall = vld[g] && !ready;
                prev_b     = cur[g];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TOF_W-1:0] tof_of(input int v, input int k);
        return TOF_W'(v * 1024 + k * 17 + 5);
    endfunction

    task automatic push_exp(input vec_t vv, input int v);
        beat_t b;
        int    n;
        int    k;
        for (int g = 0; g < 2; g++) begin
            n = (g == 0) ? vv.n0 : vv.n1;
            if (n == 0) begin
                b      = '0;
                b.last = 1'b1;
                q[g].push_back(b);
            end else begin
                for (int j = 0; j < n; j++) begin
                    k       = (g == 0) ? vv.idx0[j] : vv.idx1[j];
                    b.tof   = tof_of(v, k);
                    b.inten = INT_W'(vv.ints[k]);
                    b.num   = NUM_W'(n);
                    b.last  = (j == n - 1);
                    q[g].push_back(b);
                end
            end
        end
    endtask

    // A strong stray hit in IDLE and on the frame_start cycle must both be ignored.
    task automatic drive_frame(input vec_t vv, input int v);
        hit_valid = 1'b1;
        hit_tof   = '1;
        hit_int   = '1;
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        hit_valid   = 1'b0;
        for (int k = 0; k < vv.n; k++) begin
            hit_valid = 1'b1;
            hit_tof   = tof_of(v, k);
            hit_int   = INT_W'(vv.ints[k]);
            if (vv.coinc && k == vv.n - 1) begin
                frame_end = 1'b1;
                push_exp(vv, v);
            end
            step();
            hit_valid = 1'b0;
            frame_end = 1'b0;
            if (k % 2 == 1) step();
        end
        if (!(vv.coinc && vv.n > 0)) begin
            frame_end = 1'b1;
            push_exp(vv, v);
            step();
            frame_end = 1'b0;
        end
    endtask

    task automatic wait_drain(input bit rand_rdy);
        int c;
        c = 0;
        while ((q[0].size() != 0 || q[1].size() != 0 || vld[0] || vld[1]) && c < 300) begin
            ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            c++;
        end
        ready = 1'b1;
        if (c >= 300) begin
            flag("drain_timeout", $sformatf("queues %0d/%0d left after %0d cycles, expected 0",
                                            q[0].size(), q[1].size(), c));
        end
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        while (!vld[0] && c < 50) begin
            step();
            c++;
        end
        if (c >= 50) flag("valid_timeout", "TDC_Ovalid stayed 0, expected 1");
    endtask

    vec_t vv;
    int   base;
    bit   seen;

    initial begin
        vecs[0] = '{n: 5, ints: '{4, 9, 2, 7, 2, 0}, coinc: 1'b0, n0: 3, idx0: '{0, 1, 3},
                    n1: 3, idx1: '{0, 1, 2}, hits: 5, drops: 2};
        vecs[1] = '{n: 0, ints: '{0, 0, 0, 0, 0, 0}, coinc: 1'b0, n0: 0, idx0: '{0, 0, 0},
                    n1: 0, idx1: '{0, 0, 0}, hits: 0, drops: 0};
        vecs[2] = '{n: 5, ints: '{3, 3, 5, 3, 4, 0}, coinc: 1'b0, n0: 3, idx0: '{4, 1, 2},
                    n1: 3, idx1: '{0, 1, 2}, hits: 5, drops: 2};
        vecs[3] = '{n: 2, ints: '{1, 6, 0, 0, 0, 0}, coinc: 1'b1, n0: 2, idx0: '{0, 1, 0},
                    n1: 2, idx1: '{0, 1, 0}, hits: 2, drops: 0};
        vecs[4] = '{n: 6, ints: '{5, 1, 8, 9, 2, 9}, coinc: 1'b1, n0: 3, idx0: '{5, 3, 2},
                    n1: 3, idx1: '{0, 1, 2}, hits: 6, drops: 3};
        vecs[5] = '{n: 1, ints: '{7, 0, 0, 0, 0, 0}, coinc: 1'b0, n0: 1, idx0: '{0, 0, 0},
                    n1: 1, idx1: '{0, 0, 0}, hits: 1, drops: 0};

        rst = 1'b1;
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset_valid_m%0d", g), 32'(vld[g]), 32'd0);
            chk($sformatf("reset_beat_m%0d", g), 32'(cur[g]), 32'd0);
            chk($sformatf("reset_hit_cnt_m%0d", g), 32'(hit_cnt[g]), 32'd0);
            chk($sformatf("reset_drop_cnt_m%0d", g), 32'(drop_cnt[g]), 32'd0);
            chk($sformatf("reset_overrun_m%0d", g), 32'(overrun[g]), 32'd0);
        end
        rst = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            drive_frame(vecs[v], v);
            wait_drain(1'b1);
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("vec%0d_hit_cnt_m%0d", v, g), 32'(hit_cnt[g]), 32'(vecs[v].hits));
                chk($sformatf("vec%0d_drop_cnt_m%0d", v, g), 32'(drop_cnt[g]), 32'(vecs[v].drops));
            end
            step();
        end

        // Backpressure: first beat must appear one cycle after frame_end and hold for 5 stalls.
        vv   = '{n: 2, ints: '{12, 3, 0, 0, 0, 0}, coinc: 1'b0, n0: 2, idx0: '{0, 1, 0},
                 n1: 2, idx1: '{0, 1, 0}, hits: 2, drops: 0};
        base = beats_seen[0];
        ready = 1'b0;
        drive_frame(vv, 10);
        chk("bp_first_valid_latency", 32'(vld[0]), 32'd1);
        repeat (5) step();
        chk("bp_beat0_held", 32'(cur[0]), 32'({tof_of(10, 0), 5'd12, 2'd2, 1'b0}));
        wait_drain(1'b0);
        chk("bp_transfers", 32'(beats_seen[0] - base), 32'd2);
        step();

        // frame_start while draining: overrun set, drain intact, lone frame_end in IDLE ignored.
        vv = '{n: 3, ints: '{10, 20, 30, 0, 0, 0}, coinc: 1'b0, n0: 3, idx0: '{0, 1, 2},
               n1: 3, idx1: '{0, 1, 2}, hits: 3, drops: 0};
        ready = 1'b0;
        drive_frame(vv, 11);
        step();
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("overrun_set_m0", 32'(overrun[0]), 32'd1);
        chk("overrun_set_m1", 32'(overrun[1]), 32'd1);
        wait_drain(1'b0);
        chk("overrun_frame_hits", 32'(hit_cnt[0]), 32'd3);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            if (vld[0] || vld[1]) seen = 1'b1;
            step();
        end
        chk("idle_frame_end_no_stream", 32'(seen), 32'd0);
        chk("idle_frame_end_hits_held", 32'(hit_cnt[0]), 32'd3);
        chk("overrun_sticky", 32'(overrun[0]), 32'd1);

        // Reset in the middle of a drain.
        vv = '{n: 2, ints: '{1, 2, 0, 0, 0, 0}, coinc: 1'b0, n0: 2, idx0: '{0, 1, 0},
               n1: 2, idx1: '{0, 1, 0}, hits: 2, drops: 0};
        ready = 1'b0;
        drive_frame(vv, 12);
        wait_valid();
        step();
        rst = 1'b1;
        #1;
        chk("rst_valid_m0", 32'(vld[0]), 32'd0);
        chk("rst_valid_m1", 32'(vld[1]), 32'd0);
        chk("rst_beat_m0", 32'(cur[0]), 32'd0);
        q[0].delete();
        q[1].delete();
        step();
        rst   = 1'b0;
        ready = 1'b1;
        step();
        chk("rst_overrun_cleared", 32'(overrun[0]), 32'd0);
        chk("rst_hit_cnt_cleared", 32'(hit_cnt[0]), 32'd0);
        chk("rst_no_partial_beat", 32'(vld[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
